// File: rtl/tx_pkg.sv
// Shared types, PRBS tap positions and level-mapping helpers for the PRBS/FFE transmitter.
package tx_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPreamble = 2'd1,
    StData     = 2'd2
  } tx_state_e;

  // Feedback taps as bit indices of the shift register (x^7+x^6+1, x^15+x^14+1).
  localparam int unsigned Prbs7TapHi  = 6;
  localparam int unsigned Prbs7TapLo  = 5;
  localparam int unsigned Prbs15TapHi = 14;
  localparam int unsigned Prbs15TapLo = 13;

  function automatic int unsigned prbs_tap_hi(int unsigned order);
    return (order == 15) ? Prbs15TapHi : Prbs7TapHi;
  endfunction

  function automatic int unsigned prbs_tap_lo(int unsigned order);
    return (order == 15) ? Prbs15TapLo : Prbs7TapLo;
  endfunction

  function automatic real gray_level(logic [1:0] code, real amp);
    real lvl;
    unique case (code)
      2'b00:   lvl = -amp;
      2'b01:   lvl = -amp / 3.0;
      2'b11:   lvl = amp / 3.0;
      default: lvl = amp;
    endcase
    return lvl;
  endfunction

  function automatic real pam2_level(logic bit_val, real amp);
    return bit_val ? amp : -amp;
  endfunction

endpackage

// File: rtl/tx_prbs_ffe_driver_if.sv
// Run control in, channel-facing level and symbol observation out.
interface tx_prbs_ffe_driver_if;
  logic       en;
  logic       err_inject;
  real        x;
  logic [1:0] sym;
  logic       sym_valid;
  logic [1:0] state;

  modport master (
    output en, err_inject,
    input  x, sym, sym_valid, state
  );

  modport slave (
    input  en, err_inject,
    output x, sym, sym_valid, state
  );
endinterface

// File: rtl/prbs_gen.sv
// Fibonacci LFSR producing BitsPerUi bits per step; o_bits holds the bits the next step emits,
// MSB first. Load takes priority over step.
module prbs_gen
  import tx_pkg::*;
#(
  parameter int unsigned      Order     = 7,
  parameter logic [Order-1:0] Seed      = '1,
  parameter int unsigned      BitsPerUi = 1
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 i_load,
  input  logic                 i_step,
  output logic [BitsPerUi-1:0] o_bits
);

  localparam int unsigned TapHi = prbs_tap_hi(Order);
  localparam int unsigned TapLo = prbs_tap_lo(Order);

  logic [Order-1:0] r_lfsr;
  logic [Order-1:0] w_lfsr_next;

  always_comb begin
    w_lfsr_next = r_lfsr;
    o_bits      = '0;
    for (int unsigned i = 0; i < BitsPerUi; i++) begin
      o_bits[BitsPerUi-1-i] = w_lfsr_next[TapHi] ^ w_lfsr_next[TapLo];
      w_lfsr_next           = {w_lfsr_next[Order-2:0], o_bits[BitsPerUi-1-i]};
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_lfsr <= Seed;
    end else if (i_load) begin
      r_lfsr <= Seed;
    end else if (i_step) begin
      r_lfsr <= w_lfsr_next;
    end
  end

endmodule

// File: rtl/tx_prbs_ffe_driver.sv
// Behavioural transmitter: preamble then PRBS data, PAM2/PAM4 mapping and a 3-tap FFE,
// emitting one zero-order-hold level per UI.
module tx_prbs_ffe_driver
  import tx_pkg::*;
#(
  parameter int unsigned           PRBS_ORDER   = 7,
  parameter bit                    PAM4         = 1'b0,
  parameter logic [PRBS_ORDER-1:0] SEED         = '1,
  parameter int unsigned           PREAMBLE_LEN = 32,
  parameter real                   AMP          = 1.0,
  parameter real                   C_PRE        = -0.1,
  parameter real                   C_MAIN       = 0.8,
  parameter real                   C_POST       = -0.1
) (
  input logic                 clk,
  input logic                 rstb,
  tx_prbs_ffe_driver_if.slave tx_if
);

  localparam int unsigned BitsPerUi = PAM4 ? 2 : 1;
  localparam logic [9:0]  PreLast   = 10'(PREAMBLE_LEN - 1);

  tx_state_e  r_state;
  logic [9:0] r_pre_cnt;
  real        r_d_next, r_d_cur, r_d_prev, r_x;
  logic [1:0] r_c_next, r_c_cur, r_sym;
  logic       r_v_next, r_v_cur, r_sym_valid;

  logic [BitsPerUi-1:0] w_bits;
  logic                 w_data;
  logic                 w_msb;
  logic [1:0]           w_code;
  real                  w_level;

  assign w_data = (r_state == StData);

  prbs_gen #(
    .Order     (PRBS_ORDER),
    .Seed      (SEED),
    .BitsPerUi (BitsPerUi)
  ) u_prbs_gen (
    .clk    (clk),
    .rstb   (rstb),
    .i_load (!tx_if.en),
    .i_step (tx_if.en && w_data),
    .o_bits (w_bits)
  );

  // Injected error flips only the emitted bit; the LFSR keeps its true sequence.
  assign w_msb = w_bits[BitsPerUi-1] ^ tx_if.err_inject;

  always_comb begin
    w_code  = 2'b00;
    w_level = 0.0;
    unique case (r_state)
      StPreamble: w_level = r_pre_cnt[0] ? -AMP : AMP;
      StData: begin
        if (PAM4) begin
          w_code  = {w_msb, w_bits[0]};
          w_level = gray_level(w_code, AMP);
        end else begin
          w_code  = {1'b0, w_msb};
          w_level = pam2_level(w_msb, AMP);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= StIdle;
      r_pre_cnt   <= '0;
      r_d_next    <= 0.0;
      r_d_cur     <= 0.0;
      r_d_prev    <= 0.0;
      r_x         <= 0.0;
      r_c_next    <= 2'b00;
      r_c_cur     <= 2'b00;
      r_sym       <= 2'b00;
      r_v_next    <= 1'b0;
      r_v_cur     <= 1'b0;
      r_sym_valid <= 1'b0;
    end else if (!tx_if.en) begin
      // Disable flushes the delay line at once: no FFE tail.
      r_state     <= StIdle;
      r_pre_cnt   <= '0;
      r_d_next    <= 0.0;
      r_d_cur     <= 0.0;
      r_d_prev    <= 0.0;
      r_x         <= 0.0;
      r_c_next    <= 2'b00;
      r_c_cur     <= 2'b00;
      r_sym       <= 2'b00;
      r_v_next    <= 1'b0;
      r_v_cur     <= 1'b0;
      r_sym_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_state   <= StPreamble;
          r_pre_cnt <= '0;
        end
        StPreamble: begin
          r_pre_cnt <= r_pre_cnt + 10'd1;
          if (r_pre_cnt == PreLast) r_state <= StData;
        end
        default: ;
      endcase
      r_d_next    <= w_level;
      r_d_cur     <= r_d_next;
      r_d_prev    <= r_d_cur;
      r_c_next    <= w_code;
      r_c_cur     <= r_c_next;
      r_sym       <= r_c_cur;
      r_v_next    <= w_data;
      r_v_cur     <= r_v_next;
      r_sym_valid <= r_v_cur;
      r_x         <= C_PRE * r_d_next + C_MAIN * r_d_cur + C_POST * r_d_prev;
    end
  end

  assign tx_if.x         = r_x;
  assign tx_if.sym       = r_sym;
  assign tx_if.sym_valid = r_sym_valid;
  assign tx_if.state     = r_state;

endmodule

// File: tb/tb_tx_prbs_ffe_driver.sv
// Three transmitter configurations driven by shared random run control, each checked against
// a model that derives every UI's level from its position in the run.
module tb_tx_prbs_ffe_driver;

  localparam int NCfg    = 3;
  localparam int MaxBits = 4096;
  localparam int MaxData = 1024;

  logic clk;
  logic rstb;
  logic en;
  logic err;

  tx_prbs_ffe_driver_if if0 ();
  tx_prbs_ffe_driver_if if1 ();
  tx_prbs_ffe_driver_if if2 ();

  assign if0.en = en;
  assign if1.en = en;
  assign if2.en = en;
  assign if0.err_inject = err;
  assign if1.err_inject = err;
  assign if2.err_inject = err;

  tx_prbs_ffe_driver #(
    .PRBS_ORDER (7), .PAM4 (1'b0), .SEED (7'h7F), .PREAMBLE_LEN (4),
    .AMP (1.0), .C_PRE (0.0), .C_MAIN (1.0), .C_POST (0.0)
  ) u_dut0 (.clk (clk), .rstb (rstb), .tx_if (if0));

  tx_prbs_ffe_driver #(
    .PRBS_ORDER (7), .PAM4 (1'b0), .SEED (7'h7F), .PREAMBLE_LEN (6),
    .AMP (1.0), .C_PRE (-0.1), .C_MAIN (0.8), .C_POST (-0.1)
  ) u_dut1 (.clk (clk), .rstb (rstb), .tx_if (if1));

  tx_prbs_ffe_driver #(
    .PRBS_ORDER (15), .PAM4 (1'b1), .SEED (15'h7FFF), .PREAMBLE_LEN (5),
    .AMP (1.0), .C_PRE (0.0), .C_MAIN (1.0), .C_POST (0.0)
  ) u_dut2 (.clk (clk), .rstb (rstb), .tx_if (if2));

  int  cfg_order [NCfg] = '{7, 7, 15};
  bit  cfg_pam4  [NCfg] = '{1'b0, 1'b0, 1'b1};
  int  cfg_len   [NCfg] = '{4, 6, 5};
  real cfg_amp   [NCfg] = '{1.0, 1.0, 1.0};
  real cfg_pre   [NCfg] = '{0.0, -0.1, 0.0};
  real cfg_main  [NCfg] = '{1.0, 0.8, 1.0};
  real cfg_post  [NCfg] = '{0.0, -0.1, 0.0};

  bit  prbs_bits [2][MaxBits];
  bit  err_flag  [NCfg][MaxData];
  int  t_run     [NCfg];
  real exp_x     [NCfg];
  int  exp_sym   [NCfg];
  int  exp_vld   [NCfg];
  int  exp_state [NCfg];

  int n_cmp;
  int n_bad;
  int edge_cnt;
  int run_len;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input real got, input real want);
    n_cmp++;
    if ((got - want) > 1e-9 || (want - got) > 1e-9) begin
      n_bad++;
      $display("FAIL %s: got %g, expected %g", tag, got, want);
    end
  endtask

  // Seed all ones means every bit "before" the sequence reads as 1.
  task automatic gen_prbs();
    int ord;
    bit a;
    bit b;
    for (int k = 0; k < 2; k++) begin
      ord = (k == 0) ? 7 : 15;
      for (int n = 0; n < MaxBits; n++) begin
        a = (n - ord < 0) ? 1'b1 : prbs_bits[k][n-ord];
        b = (n - ord + 1 < 0) ? 1'b1 : prbs_bits[k][n-ord+1];
        prbs_bits[k][n] = a ^ b;
      end
    end
  endtask

  function automatic bit data_bit(input int c, input int idx);
    return prbs_bits[(cfg_order[c] == 15) ? 1 : 0][idx];
  endfunction

  // Level/code/valid of the symbol generated at run edge t (t = 0 is the enabling edge).
  function automatic void ref_sym(input int c, input int t, output real lvl,
                                  output int code, output int vld);
    int  n;
    bit  b1;
    bit  b0;
    real amp;
    amp  = cfg_amp[c];
    lvl  = 0.0;
    code = 0;
    vld  = 0;
    if (t >= 1 && t <= cfg_len[c]) begin
      lvl = ((t - 1) % 2 == 0) ? amp : -amp;
    end else if (t > cfg_len[c]) begin
      n   = t - 1 - cfg_len[c];
      vld = 1;
      if (cfg_pam4[c]) begin
        b1   = data_bit(c, 2 * n) ^ err_flag[c][n];
        b0   = data_bit(c, 2 * n + 1);
        code = 2 * int'(b1) + int'(b0);
        if (code == 0)      lvl = -amp;
        else if (code == 1) lvl = -amp / 3.0;
        else if (code == 3) lvl = amp / 3.0;
        else                lvl = amp;
      end else begin
        b1   = data_bit(c, n) ^ err_flag[c][n];
        code = int'(b1);
        lvl  = b1 ? amp : -amp;
      end
    end
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCfg; c++) begin
      t_run[c]     = -1;
      exp_x[c]     = 0.0;
      exp_sym[c]   = 0;
      exp_vld[c]   = 0;
      exp_state[c] = 0;
    end
  endtask

  task automatic model_edge(input bit en_s, input bit err_s);
    real l1, l2, l3;
    int  c1, c2, c3, v1, v2, v3;
    if (!en_s) begin
      model_clear();
    end else begin
      for (int c = 0; c < NCfg; c++) begin
        t_run[c]++;
        if (t_run[c] > cfg_len[c] && t_run[c] - 1 - cfg_len[c] < MaxData)
          err_flag[c][t_run[c]-1-cfg_len[c]] = err_s;
        ref_sym(c, t_run[c] - 1, l1, c1, v1);
        ref_sym(c, t_run[c] - 2, l2, c2, v2);
        ref_sym(c, t_run[c] - 3, l3, c3, v3);
        exp_x[c]     = cfg_pre[c] * l1 + cfg_main[c] * l2 + cfg_post[c] * l3;
        exp_sym[c]   = c2;
        exp_vld[c]   = v2;
        exp_state[c] = (t_run[c] < cfg_len[c]) ? 1 : 2;
      end
    end
  endtask

  task automatic sample(input int c, output real x, output int sym, output int vld,
                        output int st);
    case (c)
      0: begin x = if0.x; sym = int'(if0.sym); vld = int'(if0.sym_valid); st = int'(if0.state); end
      1: begin x = if1.x; sym = int'(if1.sym); vld = int'(if1.sym_valid); st = int'(if1.state); end
      default: begin
        x = if2.x; sym = int'(if2.sym); vld = int'(if2.sym_valid); st = int'(if2.state);
      end
    endcase
  endtask

  task automatic check_all();
    real x;
    int  sym, vld, st;
    for (int c = 0; c < NCfg; c++) begin
      sample(c, x, sym, vld, st);
      check($sformatf("cfg%0d x e%0d", c, edge_cnt), x, exp_x[c]);
      check($sformatf("cfg%0d sym e%0d", c, edge_cnt), real'(sym), real'(exp_sym[c]));
      check($sformatf("cfg%0d sym_valid e%0d", c, edge_cnt), real'(vld), real'(exp_vld[c]));
      check($sformatf("cfg%0d state e%0d", c, edge_cnt), real'(st), real'(exp_state[c]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(en, err);
    edge_cnt++;
    #1;
    check_all();
  endtask

  // Called at posedge+1; reset is asserted and released well clear of any edge.
  task automatic pulse_reset();
    #2 rstb = 1'b0;
    model_clear();
    #1 check_all();
    #2 rstb = 1'b1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    edge_cnt = 0;
    rstb     = 1'b0;
    en       = 1'b0;
    err      = 1'b0;
    gen_prbs();
    model_clear();
    #3 check_all();
    #5 rstb = 1'b1;

    repeat (3) step();

    // Long run: covers preamble, >2 PRBS7 periods and sparse error pulses.
    en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      err = ($urandom_range(0, 47) == 0);
      step();
    end

    // Drop enable mid-data, then replay from the seed without errors.
    en  = 1'b0;
    err = 1'b0;
    repeat (3) step();
    en = 1'b1;
    repeat (150) step();

    pulse_reset();
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    repeat (120) step();

    for (int r = 0; r < 8; r++) begin
      run_len = $urandom_range(1, 250);
      en      = 1'b1;
      for (int i = 0; i < run_len; i++) begin
        err = ($urandom_range(0, 31) == 0);
        step();
      end
      if (r % 3 == 1) pulse_reset();
      en  = 1'b0;
      err = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
